// File: rtl/alu_cmp_unit_pkg.sv
// Shared ALU definitions: comparison function codes, result codes and the
// default operand/output widths used by the ALU units.
package alu_cmp_unit_pkg;

  // Default widths shared by the arithmetic, logic, shift and compare units
  localparam int ALU_IN_WIDTH  = 8;
  localparam int ALU_OUT_WIDTH = 16;

  // 2-bit comparison function codes carried on ALU_FUN
  localparam logic [1:0] CMP_NOP = 2'b00;
  localparam logic [1:0] CMP_EQ  = 2'b01;
  localparam logic [1:0] CMP_GT  = 2'b10;
  localparam logic [1:0] CMP_LT  = 2'b11;

  // Result codes produced when the selected comparison holds
  localparam logic [1:0] RES_ZERO = 2'd0;
  localparam logic [1:0] RES_EQ   = 2'd1;
  localparam logic [1:0] RES_GT   = 2'd2;
  localparam logic [1:0] RES_LT   = 2'd3;

endpackage

// File: rtl/alu_cmp_core.sv
// Combinational core of the comparison slice: maps A, B and the function
// code onto a 2-bit result code. Comparisons are unsigned over full width.
module alu_cmp_core
  import alu_cmp_unit_pkg::*;
#(
  parameter int in_width = ALU_IN_WIDTH
) (
  input  logic [in_width-1:0] a,
  input  logic [in_width-1:0] b,
  input  logic [1:0]          alu_fun,
  output logic [1:0]          res_code
);

  // Decode the function code into the matching result code
  always_comb begin
    // NOTE: assigning a default before the case guarantees every path drives
    // res_code, so no latch is inferred and unknown codes resolve to zero.
    res_code = RES_ZERO;
    case (alu_fun)
      CMP_NOP: res_code = RES_ZERO;
      CMP_EQ:  res_code = (a == b) ? RES_EQ : RES_ZERO;
      CMP_GT:  res_code = (a > b)  ? RES_GT : RES_ZERO;
      CMP_LT:  res_code = (a < b)  ? RES_LT : RES_ZERO;
      default: res_code = RES_ZERO;
    endcase
  end

endmodule

// File: rtl/alu_cmp_unit.sv
// Comparison slice of the hierarchical ALU. Gates the core result with the
// decoder enable and registers it, zero-extended, together with a valid flag.
module alu_cmp_unit
  import alu_cmp_unit_pkg::*;
#(
  parameter int in_width  = ALU_IN_WIDTH,
  parameter int out_width = ALU_OUT_WIDTH
) (
  input  logic                 clk,
  input  logic                 RST,
  input  logic [in_width-1:0]  A,
  input  logic [in_width-1:0]  B,
  input  logic [1:0]           ALU_FUN,
  input  logic                 CMP_Enable,
  output logic [out_width-1:0] CMP_OUT,
  output logic                 CMP_Flag
);

  logic [1:0]           res_code;
  logic [out_width-1:0] res_ext;

  alu_cmp_core #(
    .in_width (in_width)
  ) u_core (
    .a        (A),
    .b        (B),
    .alu_fun  (ALU_FUN),
    .res_code (res_code)
  );

  // Zero-extend the 2-bit code to the shared ALU output width
  assign res_ext = out_width'(res_code);

  // Output registers: cleared asynchronously, zero when the unit is not selected
  always_ff @(posedge clk or negedge RST) begin
    // NOTE: non-blocking assignments keep register updates order-independent
    // so every flop samples the values present before the edge.
    if (!RST) begin
      CMP_OUT  <= '0;
      CMP_Flag <= 1'b0;
    end else if (CMP_Enable) begin
      CMP_OUT  <= res_ext;
      CMP_Flag <= 1'b1;
    end else begin
      CMP_OUT  <= '0;
      CMP_Flag <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_cmp_unit.sv
// Directed self-checking bench for alu_cmp_unit.
module tb_alu_cmp_unit;

  localparam int IW = 8;
  localparam int OW = 16;

  logic          clk_tb;
  logic          rst_tb;
  logic [IW-1:0] a_tb;
  logic [IW-1:0] b_tb;
  logic [1:0]    fun_tb;
  logic          en_tb;
  logic [OW-1:0] cmp_out;
  logic          cmp_flag;

  int checks;
  int failures;

  alu_cmp_unit #(
    .in_width  (IW),
    .out_width (OW)
  ) dut (
    .clk        (clk_tb),
    .RST        (rst_tb),
    .A          (a_tb),
    .B          (b_tb),
    .ALU_FUN    (fun_tb),
    .CMP_Enable (en_tb),
    .CMP_OUT    (cmp_out),
    .CMP_Flag   (cmp_flag)
  );

  initial clk_tb = 1'b0;
  always #5 clk_tb = ~clk_tb;

  // Drive one operation on the falling edge, let one rising edge pass, settle
  task automatic apply(input logic [IW-1:0] a, input logic [IW-1:0] b,
                       input logic [1:0] fun, input logic en);
    @(negedge clk_tb);
    a_tb   = a;
    b_tb   = b;
    fun_tb = fun;
    en_tb  = en;
    @(posedge clk_tb);
    #1;
  endtask

  task automatic test_reset();
    rst_tb = 1'b0;
    en_tb  = 1'b1;
    a_tb   = 8'd15;
    b_tb   = 8'd30;
    fun_tb = 2'b00;
    #2;
    checks++;
    if (cmp_out !== 16'd0 || cmp_flag !== 1'b0) begin
      failures++;
      $display("FAIL reset_async: out=%0d flag=%b expected out=0 flag=0", cmp_out, cmp_flag);
    end
    @(negedge clk_tb);
    rst_tb = 1'b1;
    @(posedge clk_tb);
    #1;
    checks++;
    if (cmp_out !== 16'd0 || cmp_flag !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_nop: out=%0d flag=%b expected out=0 flag=1", cmp_out, cmp_flag);
    end
  endtask

  task automatic test_eq();
    logic [IW-1:0] av [2] = '{8'd50, 8'd25};
    logic [IW-1:0] bv [2] = '{8'd50, 8'd23};
    logic [OW-1:0] ev [2] = '{16'd1, 16'd0};
    for (int i = 0; i < 2; i++) begin
      apply(av[i], bv[i], 2'b01, 1'b1);
      checks++;
      if (cmp_out !== ev[i] || cmp_flag !== 1'b1) begin
        failures++;
        $display("FAIL eq[%0d] A=%0d B=%0d: out=%0d flag=%b expected out=%0d flag=1",
                 i, av[i], bv[i], cmp_out, cmp_flag, ev[i]);
      end
    end
  endtask

  task automatic test_gt();
    logic [IW-1:0] av [3] = '{8'd50, 8'd240, 8'd255};
    logic [IW-1:0] bv [3] = '{8'd15, 8'd245, 8'd0};
    logic [OW-1:0] ev [3] = '{16'd2, 16'd0, 16'd2};
    for (int i = 0; i < 3; i++) begin
      apply(av[i], bv[i], 2'b10, 1'b1);
      checks++;
      if (cmp_out !== ev[i] || cmp_flag !== 1'b1) begin
        failures++;
        $display("FAIL gt[%0d] A=%0d B=%0d: out=%0d flag=%b expected out=%0d flag=1",
                 i, av[i], bv[i], cmp_out, cmp_flag, ev[i]);
      end
    end
  endtask

  task automatic test_lt();
    logic [IW-1:0] av [3] = '{8'd10, 8'd50, 8'd255};
    logic [IW-1:0] bv [3] = '{8'd50, 8'd5, 8'd255};
    logic [OW-1:0] ev [3] = '{16'd3, 16'd0, 16'd0};
    for (int i = 0; i < 3; i++) begin
      apply(av[i], bv[i], 2'b11, 1'b1);
      checks++;
      if (cmp_out !== ev[i] || cmp_flag !== 1'b1) begin
        failures++;
        $display("FAIL lt[%0d] A=%0d B=%0d: out=%0d flag=%b expected out=%0d flag=1",
                 i, av[i], bv[i], cmp_out, cmp_flag, ev[i]);
      end
    end
  endtask

  task automatic test_boundary();
    logic [IW-1:0] av [7] = '{8'd0, 8'd255, 8'd0, 8'd0, 8'd255, 8'd255, 8'd3};
    logic [IW-1:0] bv [7] = '{8'd0, 8'd255, 8'd0, 8'd0, 8'd255, 8'd0,   8'd200};
    logic [1:0]    fv [7] = '{2'b01, 2'b01, 2'b10, 2'b11, 2'b10, 2'b11, 2'b00};
    logic [OW-1:0] ev [7] = '{16'd1, 16'd1, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    for (int i = 0; i < 7; i++) begin
      apply(av[i], bv[i], fv[i], 1'b1);
      checks++;
      if (cmp_out !== ev[i] || cmp_flag !== 1'b1) begin
        failures++;
        $display("FAIL boundary[%0d] A=%0d B=%0d fun=%0d: out=%0d flag=%b expected out=%0d flag=1",
                 i, av[i], bv[i], fv[i], cmp_out, cmp_flag, ev[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    apply(8'd50, 8'd15, 2'b10, 1'b1);
    checks++;
    if (cmp_out !== 16'd2 || cmp_flag !== 1'b1) begin
      failures++;
      $display("FAIL midrst_pre: out=%0d flag=%b expected out=2 flag=1", cmp_out, cmp_flag);
    end
    #2;
    rst_tb = 1'b0;
    #1;
    checks++;
    if (cmp_out !== 16'd0 || cmp_flag !== 1'b0) begin
      failures++;
      $display("FAIL midrst_async: out=%0d flag=%b expected out=0 flag=0", cmp_out, cmp_flag);
    end
    // Hold reset across a rising edge with the unit still enabled
    @(posedge clk_tb);
    #1;
    checks++;
    if (cmp_out !== 16'd0 || cmp_flag !== 1'b0) begin
      failures++;
      $display("FAIL midrst_hold: out=%0d flag=%b expected out=0 flag=0", cmp_out, cmp_flag);
    end
    @(negedge clk_tb);
    rst_tb = 1'b1;
    @(posedge clk_tb);
    #1;
    checks++;
    if (cmp_out !== 16'd2 || cmp_flag !== 1'b1) begin
      failures++;
      $display("FAIL midrst_release: out=%0d flag=%b expected out=2 flag=1", cmp_out, cmp_flag);
    end
  endtask

  task automatic test_enable_gating();
    apply(8'd10, 8'd50, 2'b11, 1'b1);
    checks++;
    if (cmp_out !== 16'd3 || cmp_flag !== 1'b1) begin
      failures++;
      $display("FAIL gate_pre: out=%0d flag=%b expected out=3 flag=1", cmp_out, cmp_flag);
    end
    apply(8'd10, 8'd50, 2'b11, 1'b0);
    checks++;
    if (cmp_out !== 16'd0 || cmp_flag !== 1'b0) begin
      failures++;
      $display("FAIL gate_off: out=%0d flag=%b expected out=0 flag=0", cmp_out, cmp_flag);
    end
    apply(8'd10, 8'd50, 2'b11, 1'b1);
    checks++;
    if (cmp_out !== 16'd3 || cmp_flag !== 1'b1) begin
      failures++;
      $display("FAIL gate_on: out=%0d flag=%b expected out=3 flag=1", cmp_out, cmp_flag);
    end
  endtask

  task automatic test_back_to_back();
    // Consecutive edges with changing functions: each result lasts one cycle
    logic [IW-1:0] av [4] = '{8'd7, 8'd9, 8'd1, 8'd4};
    logic [IW-1:0] bv [4] = '{8'd7, 8'd2, 8'd8, 8'd4};
    logic [1:0]    fv [4] = '{2'b01, 2'b10, 2'b11, 2'b10};
    logic [OW-1:0] ev [4] = '{16'd1, 16'd2, 16'd3, 16'd0};
    for (int i = 0; i < 4; i++) begin
      apply(av[i], bv[i], fv[i], 1'b1);
      checks++;
      if (cmp_out !== ev[i] || cmp_flag !== 1'b1) begin
        failures++;
        $display("FAIL b2b[%0d] A=%0d B=%0d fun=%0d: out=%0d flag=%b expected out=%0d flag=1",
                 i, av[i], bv[i], fv[i], cmp_out, cmp_flag, ev[i]);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_eq();
    test_gt();
    test_lt();
    test_boundary();
    test_reset_mid();
    test_enable_gating();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
